pipe_stage_reg: RTL
===================

Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register, the successor to the fixed fetch→decode register. It carries pc, instruction and commit-info payload with a valid/ready handshake, a stall hold and a flush (bubble). An optional 2-entry skid keeps full throughput while in_ready stays registered. One instance is used per stage boundary (F/D, D/E, E/M, M/W).

Parameters:
PC_W, 64, pc width
INSTR_W, 32, instruction width
INFO_W, 161, commit-info width
SKID, 0, 0 = single entry with combinational in_ready; 1 = main + skid entry with registered in_ready

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous reset, active low
flush  in  1  bubble: invalidate stage contents
stall  in  1  hold: block output transfer
in_valid  in  1  upstream payload valid
in_ready  out  1  stage accepts payload
in_pc  in  PC_W  upstream pc
in_instr  in  INSTR_W  upstream instruction
in_info  in  INFO_W  upstream commit info
out_valid  out  1  stage holds valid payload
out_ready  in  1  downstream accepts
out_pc  out  PC_W  registered pc
out_instr  out  INSTR_W  registered instruction
out_info  out  INFO_W  registered commit info

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low (rst_n). Reset forces all payload registers to 0 and all valid bits to 0. Every output is 0 during reset and on the first cycle after it, except in_ready, which is 0 only while rst_n=0.
- Transfers: in_fire = in_valid & in_ready. out_fire = out_valid & out_ready & ~stall.
- Latency: exactly 1 cycle from in_fire to out_valid when the stage is empty.
- Invalid entries always hold all-zero payload. out_instr=0 therefore marks a bubble, as downstream decode expects.
- flush has the highest priority after reset. Next cycle, every entry is invalid and its payload is 0. A same-cycle in_valid is dropped, and in_ready is forced 0 during flush so upstream sees no handshake. out_fire in the flush cycle is not suppressed.
- stall: the main entry is held and out_valid is unchanged. SKID=0: in_ready=0. SKID=1: in_ready per skid rule; a payload may still be captured into an empty main entry or into the skid.
- SKID=0:
  - in_ready = ~out_valid | (out_ready & ~stall), combinational.
  - On in_fire, the main entry loads the input.
  - On out_fire without in_fire, the main entry clears.
- SKID=1:
  - in_ready = ~skid_valid, from a register.
  - in_fire while main is empty, or main fires out: load main, unless skid is valid.
  - in_fire while main is full and not firing: load skid.
  - On out_fire with skid valid: skid moves to main and skid clears.
  - Ordering is strictly FIFO. No payload is ever duplicated or lost except by flush.
- Backpressure held indefinitely: outputs stay stable, and out_valid never drops without out_fire or flush.
- Simultaneous out_fire and in_fire when full (SKID=0): replace in the same cycle, sustaining 1 transfer/cycle.

Optional Feature:
- Macro PIPE_STAGE_REG_PERF_EN.
- Defined: adds output perf_stall_cnt (32 bits, counts cycles with out_valid & stall) and output perf_flush_cnt (32 bits, counts flush cycles that discard at least one valid entry or in_valid). Both saturate at 0xFFFF_FFFF and reset to 0.
- Undefined: neither port nor counter exists. Functional behaviour is identical.

Decomposition:
- Package pipe_pkg:
  - PC_W_DEF, INSTR_W_DEF, INFO_W_DEF constants.
  - NOP_INSTR = 0.
  - Packed struct typedef stage_payload_t {pc, instr, info}.
- Sub-module pipe_stage_entry: one valid + payload register with load/clear/zero-on-invalid. Instantiated once for main and once for skid when SKID=1.

Test Plan:
- Reset: rst_n=0 for 2 cycles with in_valid=1, in_pc=0x8000_0000 → out_valid=0, out_pc/out_instr/out_info=0, in_ready=0. Release → in_ready=1.
- Streaming, SKID=0 and SKID=1: 8 back-to-back transfers, pc 0x1000 step 4, out_ready=1 → out_pc sequence identical, 1-cycle latency, 8 outputs in 8 cycles.
- Stall: hold stall=1 for 3 cycles with pc 0x2000 in main → out_pc stays 0x2000, out_valid=1, no out_fire. SKID=1: pc 0x2004 captured in skid, then in_ready=0. Release → 0x2000, then 0x2004.
- Flush with in_valid=1 (pc 0x3000) and a full skid → next cycle out_valid=0, out_instr=0; 0x3000 never appears; in_ready=0 in the flush cycle.
- Backpressure: out_ready=0 for 5 cycles → payload stable bit-exact; no loss on release.
- PERF (macro defined): 4 stalled-valid cycles plus 1 flush of a valid entry → perf_stall_cnt=4, perf_flush_cnt=1.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths and payload layout for the inter-stage pipeline registers.
package pipe_pkg;

  localparam int unsigned PC_W_DEF    = 64;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned INFO_W_DEF  = 161;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
    logic [INFO_W_DEF-1:0]  info;
  } stage_payload_t;

endpackage

// File: rtl/pipe_stage_reg_entry.sv
// One valid bit plus payload; the payload is forced to zero whenever the entry is invalid.
module pipe_stage_entry #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         load,
  input  logic         drop,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end else if (drop) begin
      valid <= 1'b0;
      q     <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready, stall, flush and optional 2-entry skid.
// Optional perf counters enabled by defining PIPE_STAGE_REG_PERF_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF,
  parameter int unsigned INFO_W  = INFO_W_DEF,
  parameter int unsigned SKID    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               stall,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [INFO_W-1:0]  in_info,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [INFO_W-1:0]  out_info
`ifdef PIPE_STAGE_REG_PERF_EN
  ,
  output logic [31:0]        perf_stall_cnt,
  output logic [31:0]        perf_flush_cnt
`endif
);

  localparam int unsigned W = PC_W + INSTR_W + INFO_W;

  logic [W-1:0] in_pl, main_d, main_q, skid_q;
  logic         main_v, skid_v;
  logic         main_load, main_drop;
  logic         in_fire, out_fire;

  assign in_pl    = {in_pc, in_instr, in_info};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_v & out_ready & ~stall;

  // Main refills from the skid first to keep FIFO order; with SKID=0 skid_v is tied low.
  assign main_load = (in_fire & (~main_v | out_fire)) | (out_fire & skid_v);
  assign main_drop = out_fire & ~main_load;
  assign main_d    = skid_v ? skid_q : in_pl;

  pipe_stage_entry #(.W(W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .load  (main_load),
    .drop  (main_drop),
    .d     (main_d),
    .valid (main_v),
    .q     (main_q)
  );

  generate
    if (SKID == 0) begin : g_single
      assign skid_v   = 1'b0;
      assign skid_q   = '0;
      assign in_ready = rst_n & ~flush & (~main_v | (out_ready & ~stall));
    end else begin : g_skid
      logic skid_load;
      // The skid only fills when main is occupied and not leaving this cycle.
      assign skid_load = in_fire & main_v & ~out_fire;
      assign in_ready  = rst_n & ~flush & ~skid_v;

      pipe_stage_entry #(.W(W)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .load  (skid_load),
        .drop  (out_fire),
        .d     (in_pl),
        .valid (skid_v),
        .q     (skid_q)
      );
    end
  endgenerate

  assign out_valid = main_v;
  assign out_pc    = main_q[W-1 -: PC_W];
  assign out_instr = main_q[INFO_W +: INSTR_W];
  assign out_info  = main_q[INFO_W-1:0];

`ifdef PIPE_STAGE_REG_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (main_v && stall && perf_stall_cnt != '1)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && (main_v || skid_v || in_valid) && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule
